// File: rtl/result_drain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : result_drain_ctrl                                            |
// | Description : Save-RAM port owner. Passes core writes through during       |
// |               compute, then drains a programmed window of result words     |
// |               onto a valid/ready stream. RESULT_DRAIN_RELU_EN clamps       |
// |               negative words to zero at FIFO push.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module result_drain_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int RES_W      = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = RD_LAT + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ena,
    input  logic              core_wea,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [RES_W-1:0]  core_din,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W-1:0] drain_len,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [RES_W-1:0]  ram_din,
    input  logic [RES_W-1:0]  ram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RES_W-1:0]  m_data,
    output logic              m_last,
    output logic              busy,
    output logic              drain_done,
    output logic              wr_conflict
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_done_q;
    logic               w_start;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  r_issue_cnt;
    logic [ADDR_W-1:0]  r_beat_cnt;
    logic [RD_LAT-1:0]  r_vld;
    logic [RES_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_inflight;
    logic               r_zero_done;
    logic               r_wr_conflict;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_final;
    logic               w_load;
    logic [RES_W-1:0]   w_push_data;

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign w_start  = core_done & ~r_done_q;
    assign w_load   = (r_state == c_st_idle) & w_start & (drain_len != '0);
    assign m_valid  = (r_count != '0);
    assign w_pop    = m_valid & m_ready;
    assign w_push   = r_vld[RD_LAT-1];
    assign w_final  = w_pop & (r_beat_cnt == ADDR_W'(1));
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_last   = m_valid & (r_beat_cnt == ADDR_W'(1));
    assign busy     = (r_state != c_st_idle);
    assign drain_done  = w_final | r_zero_done;
    assign wr_conflict = r_wr_conflict;

`ifdef RESULT_DRAIN_RELU_EN
    assign w_push_data = ram_dout[RES_W-1] ? '0 : ram_dout;
`else
    assign w_push_data = ram_dout;
`endif

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_cnt_w'(r_vld[i]);
        end
    end

    // Credit check counts reads still in the RAM pipe so the FIFO never overflows
    assign w_issue = (r_state == c_st_drain) && (r_issue_cnt != '0) &&
                     ((r_count + w_inflight) < c_cnt_w'(FIFO_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        ram_ena     = 1'b0;
        ram_wea     = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        case (r_state)
            c_st_idle: begin
                ram_ena  = core_ena;
                ram_wea  = core_wea;
                ram_addr = core_addr;
                ram_din  = core_din;
                if (w_load) w_state_nxt = c_st_drain;
            end
            c_st_drain: begin
                ram_ena  = w_issue;
                ram_addr = r_rd_addr;
                if ((r_issue_cnt == '0) || (w_issue && (r_issue_cnt == ADDR_W'(1))))
                    w_state_nxt = c_st_flush;
            end
            c_st_flush: begin
                if (w_final) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_done_q      <= 1'b0;
            r_zero_done   <= 1'b0;
            r_wr_conflict <= 1'b0;
            r_rd_addr     <= '0;
            r_issue_cnt   <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_q    <= core_done;
            r_zero_done <= (r_state == c_st_idle) & w_start & (drain_len == '0);
            if (busy & core_ena & core_wea) r_wr_conflict <= 1'b1;
            if (w_load) begin
                r_rd_addr   <= drain_base;
                r_issue_cnt <= drain_len;
                r_beat_cnt  <= drain_len;
            end else begin
                if (w_issue) begin
                    r_rd_addr   <= r_rd_addr + 1'b1;
                    r_issue_cnt <= r_issue_cnt - 1'b1;
                end
                if (w_pop) r_beat_cnt <= r_beat_cnt - 1'b1;
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_vld_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_vld <= '0;
                else     r_vld <= w_issue;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_vld <= '0;
                else     r_vld <= {r_vld[RD_LAT-2:0], w_issue};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_result_drain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_result_drain_ctrl                                         |
// | Description : Self-checking bench for result_drain_ctrl with RAM model     |
// |               and read-address / beat-data scoreboards.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_result_drain_ctrl;

    localparam int ADDR_W     = 16;
    localparam int RES_W      = 32;
    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_ena, core_wea, core_done;
    logic [ADDR_W-1:0] core_addr, drain_base, drain_len;
    logic [RES_W-1:0]  core_din;
    logic              ram_ena, ram_wea;
    logic [ADDR_W-1:0] ram_addr;
    logic [RES_W-1:0]  ram_din;
    logic [RES_W-1:0]  ram_dout = '0;
    logic              m_valid, m_ready, m_last;
    logic [RES_W-1:0]  m_data;
    logic              busy, drain_done, wr_conflict;

    always #5 clk = ~clk;

    result_drain_ctrl #(
        .ADDR_W(ADDR_W), .RES_W(RES_W), .RD_LAT(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst),
        .core_ena(core_ena), .core_wea(core_wea), .core_addr(core_addr), .core_din(core_din),
        .core_done(core_done), .drain_base(drain_base), .drain_len(drain_len),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .drain_done(drain_done), .wr_conflict(wr_conflict)
    );

    // Sparse RAM: untouched locations hold a fixed address-derived pattern
    logic [RES_W-1:0] ram_mem [int];
    logic [RES_W-1:0] shadow  [int];

    function automatic logic [RES_W-1:0] f_pat(input logic [ADDR_W-1:0] a);
        return {a[3:0], 12'h5A3, a};
    endfunction

    function automatic logic [RES_W-1:0] f_ram_rd(input logic [ADDR_W-1:0] a);
        return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : f_pat(a);
    endfunction

    function automatic logic [RES_W-1:0] f_shadow(input logic [ADDR_W-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : f_pat(a);
    endfunction

    function automatic logic [RES_W-1:0] f_exp(input logic [RES_W-1:0] v);
`ifdef RESULT_DRAIN_RELU_EN
        return v[RES_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) ram_mem[int'(ram_addr)] = ram_din;
            else         ram_dout <= f_ram_rd(ram_addr);
        end
    end

    int               n_total = 0;
    int               n_bad   = 0;
    logic [RES_W-1:0] exp_q    [$];
    logic [ADDR_W-1:0] exp_addr [$];
    int               issued = 0, popped = 0, mon_beats = 0;
    bit               stall_q = 0, last_q = 0, allow_done = 0;
    logic [RES_W-1:0] stall_data = '0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        int                mode;
        int                exp_beats;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon();
        logic [ADDR_W-1:0] ea;
        logic [RES_W-1:0]  ed;
        bit                hs;
        if (last_q) chk(!busy, "busy_drop", busy, 0);
        if (busy) chk(ram_wea == 1'b0, "wea_forced", ram_wea, 0);
        if (busy && ram_ena) begin
            issued++;
            chk(issued - popped <= FIFO_DEPTH, "credit", issued - popped, FIFO_DEPTH);
            if (exp_addr.size() == 0) chk(0, "extra_read", ram_addr, 0);
            else begin
                ea = exp_addr.pop_front();
                chk(ram_addr == ea, "rd_addr", ram_addr, ea);
            end
        end
        if (stall_q) chk(m_valid && (m_data == stall_data), "stall_hold", m_data, stall_data);
        hs     = m_valid && m_ready;
        last_q = 0;
        if (hs) begin
            popped++;
            mon_beats++;
            if (exp_q.size() == 0) chk(0, "extra_beat", m_data, 0);
            else begin
                ed = exp_q.pop_front();
                chk(m_data == ed, "beat_data", m_data, ed);
                chk(m_last == (exp_q.size() == 0), "m_last", m_last, exp_q.size() == 0);
                chk(drain_done == (exp_q.size() == 0), "done_pulse", drain_done, exp_q.size() == 0);
                last_q = (exp_q.size() == 0);
            end
        end else if (drain_done && !allow_done) begin
            chk(0, "spurious_done", 1, 0);
        end
        stall_q    = m_valid && !m_ready;
        stall_data = m_data;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [ADDR_W-1:0] a, input logic [RES_W-1:0] d, input bit keep);
        core_ena  = 1'b1;
        core_wea  = 1'b1;
        core_addr = a;
        core_din  = d;
        tick();
        core_ena  = 1'b0;
        core_wea  = 1'b0;
        if (keep) shadow[int'(a)] = d;
    endtask

    task automatic start_drain(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = ADDR_W'(int'(base) + i);
            exp_addr.push_back(a);
            exp_q.push_back(f_exp(f_shadow(a)));
        end
        drain_base = base;
        drain_len  = len;
        core_done  = 1'b1;
    endtask

    task automatic wait_done(input int len, input int mode, input int exp_beats);
        int b0, cnt;
        bit fin;
        b0  = mon_beats;
        cnt = 0;
        fin = 0;
        while (!fin) begin
            case (mode)
                1:       m_ready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            tick();
            cnt++;
            if ((mon_beats - b0 >= len) && !busy) fin = 1;
            else if (cnt >= 3000) begin
                chk(0, "timeout", mon_beats - b0, len);
                fin = 1;
            end
        end
        core_done = 1'b0;
        m_ready   = 1'b1;
        tick();
        chk(mon_beats - b0 == exp_beats, "beat_count", mon_beats - b0, exp_beats);
        chk(exp_q.size() == 0, "leftover", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'd2, 0, 2};
        vecs[1] = '{16'h0010, 16'd8, 1, 8};
        vecs[2] = '{16'hFFFE, 16'd4, 0, 4};
        vecs[3] = '{16'h0100, 16'd5, 2, 5};
        vecs[4] = '{16'h0200, 16'd1, 1, 1};

        rst = 1'b1;
        core_ena = 0; core_wea = 0; core_addr = '0; core_din = '0; core_done = 0;
        drain_base = '0; drain_len = '0; m_ready = 1'b1;
        #1;
        chk(m_valid == 0, "rst_m_valid", m_valid, 0);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(drain_done == 0, "rst_done", drain_done, 0);
        chk(wr_conflict == 0, "rst_conflict", wr_conflict, 0);
        chk(m_last == 0 && ram_ena == 0 && m_data == 0, "rst_outs", {m_last, ram_ena}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        core_write(16'd3, 32'h0000_0005, 1);
        core_write(16'd4, 32'hFFFF_FFFE, 1);
        chk(f_ram_rd(16'd3) == 32'h5, "wr_pass3", f_ram_rd(16'd3), 32'h5);
        chk(f_ram_rd(16'd4) == 32'hFFFF_FFFE, "wr_pass4", f_ram_rd(16'd4), 32'hFFFF_FFFE);

        for (int v = 0; v < 5; v++) begin
            start_drain(vecs[v].base, vecs[v].len);
            wait_done(int'(vecs[v].len), vecs[v].mode, vecs[v].exp_beats);
        end

        // Zero-length drain: lone done pulse one cycle after the edge
        allow_done = 1;
        drain_len  = '0;
        core_done  = 1'b1;
        chk(drain_done == 0, "zl_pre", drain_done, 0);
        tick();
        chk(drain_done == 1, "zl_pulse", drain_done, 1);
        chk(busy == 0, "zl_busy", busy, 0);
        tick();
        chk(drain_done == 0, "zl_clear", drain_done, 0);
        chk(m_valid == 0, "zl_no_valid", m_valid, 0);
        core_done  = 1'b0;
        allow_done = 0;
        tick();

        // Core write and done re-rise while draining
        start_drain(16'd40, 16'd6);
        m_ready = 1'b0;
        repeat (3) tick();
        core_write(16'd500, 32'hDEAD_BEEF, 0);
        core_done = 1'b0;
        tick();
        core_done = 1'b1;
        wait_done(6, 1, 6);
        chk(f_ram_rd(16'd500) == f_shadow(16'd500), "wr_dropped", f_ram_rd(16'd500), f_shadow(16'd500));
        chk(wr_conflict == 1, "conflict_set", wr_conflict, 1);
        repeat (3) tick();
        chk(wr_conflict == 1, "conflict_sticky", wr_conflict, 1);
        chk(busy == 0, "no_restart", busy, 0);

        // Reset after beat 2 of 6, then a full re-drain
        begin
            int b0, cnt;
            start_drain(16'd60, 16'd6);
            m_ready = 1'b1;
            b0  = mon_beats;
            cnt = 0;
            while ((mon_beats - b0 < 2) && (cnt < 200)) begin
                tick();
                cnt++;
            end
            chk(mon_beats - b0 == 2, "pre_rst_beats", mon_beats - b0, 2);
        end
        rst = 1'b1;
        #1;
        chk(m_valid == 0, "rst_mid_valid", m_valid, 0);
        chk(busy == 0, "rst_mid_busy", busy, 0);
        chk(wr_conflict == 0, "rst_mid_conflict", wr_conflict, 0);
        exp_q.delete();
        exp_addr.delete();
        issued = 0; popped = 0; stall_q = 0; last_q = 0;
        core_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        start_drain(16'd60, 16'd6);
        wait_done(6, 2, 6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
